// File: rtl/fifo_r_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_r_ctrl_pkg
//  Description : Shared definitions for the fifo_r read-side sequencer.
//                This file holds the state encoding, the status codes seen by
//                fifo_r and software, the word geometry, and a helper that
//                maps a state to its status code.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_r_ctrl_pkg;

  // Sequencer states. STATE_ERR is only reachable when the timeout watchdog
  // is built in.
  typedef enum logic [2:0] {
    STATE_IDLE  = 3'd0,
    STATE_REQ   = 3'd1,
    STATE_LOAD  = 3'd2,
    STATE_SHIFT = 3'd3,
    STATE_DONE  = 3'd4,
    STATE_ERR   = 3'd5
  } state_e;

  // Status codes
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_FETCH  = 2'b01;
  localparam logic [1:0] ST_STREAM = 2'b10;
  localparam logic [1:0] ST_ERR    = 2'b11;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE      = 2'(BYTES_PER_WORD - 1);

  // LOAD still belongs to the fetch phase. DONE reports idle because the
  // frame has already been fully streamed.
  function automatic logic [1:0] status_of(input logic [2:0] s);
    logic [1:0] code;
    code = ST_IDLE;
    case (s)
      STATE_REQ,
      STATE_LOAD:  code = ST_FETCH;
      STATE_SHIFT: code = ST_STREAM;
      STATE_ERR:   code = ST_ERR;
      default:     code = ST_IDLE;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_r_ctrl_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_r_ctrl_wdog
//  Description : AHB request watchdog. It counts consecutive cycles with `run`
//                high and flags `expired` during the TIMEOUT_CYC-th such
//                cycle. The count clears whenever `run` is low.
//  Ports       : clk     - clock
//                rst_n   - synchronous active-low reset
//                run     - sequencer is waiting in REQ
//                expired - combinational; last allowed REQ cycle passing
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_r_ctrl_wdog #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int            CW    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + ONE;
    end
  end

  // cnt holds the number of REQ cycles already spent, so the match fires in
  // the TIMEOUT_CYC-th REQ cycle.
  assign expired = run && (cnt == LIMIT);

endmodule
`default_nettype wire

// File: rtl/fifo_r_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_r_ctrl
//  Description : Sequencer for the AHB read-side byte FIFO (fifo_r). It
//                requests one 32-bit word per AHB beat and loads it into
//                fifo_r. It then shifts the four bytes out under downstream
//                backpressure, and repeats until the programmed word count
//                is exhausted.
//  Build macro : FIFO_R_CTRL_TIMEOUT_EN - adds the REQ watchdog and ERR state
//  Ports       : HCLK, HRESETn      - clock, synchronous active-low reset
//                start, num_words   - frame start pulse and word count
//                ahb_req / ahb_done - one-beat read handshake with AHB master
//                byte_ready         - downstream accepts current byte
//                load_enable,
//                shift_enable       - fifo_r controls (shift is combinational)
//                status             - 00 idle, 01 fetch, 10 stream, 11 error
//                byte_valid, busy,
//                frame_done         - registered status flags
//                words_left         - words remaining incl. the one in flight
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_r_ctrl
  import fifo_r_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  output logic             ahb_req,
  input  logic             ahb_done,
  input  logic             byte_ready,
  output logic             load_enable,
  output logic             shift_enable,
  output logic [1:0]       status,
  output logic             byte_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] words_left
);

  localparam logic [2:0] S_IDLE  = STATE_IDLE;
  localparam logic [2:0] S_REQ   = STATE_REQ;
  localparam logic [2:0] S_LOAD  = STATE_LOAD;
  localparam logic [2:0] S_SHIFT = STATE_SHIFT;
  localparam logic [2:0] S_DONE  = STATE_DONE;
`ifdef FIFO_R_CTRL_TIMEOUT_EN
  localparam logic [2:0] S_ERR   = STATE_ERR;
`endif

  localparam logic [CNT_W-1:0] WORD_ONE = CNT_W'(1);

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [1:0]       byte_cnt;
  logic [1:0]       byte_cnt_nx;
  logic [CNT_W-1:0] words_left_nx;

`ifdef FIFO_R_CTRL_TIMEOUT_EN
  logic timeout;

  fifo_r_ctrl_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk     (HCLK),
    .rst_n   (HRESETn),
    .run     (state == S_REQ),
    .expired (timeout)
  );
`endif

  always_comb begin
    state_nx      = state;
    byte_cnt_nx   = byte_cnt;
    words_left_nx = words_left;
    case (state)
      S_IDLE: begin
        if (start) begin
          words_left_nx = num_words;
          state_nx      = (num_words != '0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (ahb_done) begin
          state_nx = S_LOAD;
`ifdef FIFO_R_CTRL_TIMEOUT_EN
        end else if (timeout) begin
          state_nx = S_ERR;
`endif
        end
      end
      S_LOAD: begin
        byte_cnt_nx = '0;
        state_nx    = S_SHIFT;
      end
      S_SHIFT: begin
        if (byte_ready) begin
          // The counter wraps 3->0 in the same cycle that the word-exit
          // decision is made.
          byte_cnt_nx = byte_cnt + 2'd1;
          if (byte_cnt == LAST_BYTE) begin
            words_left_nx = words_left - WORD_ONE;
            state_nx      = (words_left != WORD_ONE) ? S_REQ : S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
`ifdef FIFO_R_CTRL_TIMEOUT_EN
      S_ERR: begin
        if (start) begin
          state_nx = S_IDLE;
        end
      end
`endif
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they are registered and
  // line up with the state they describe.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      words_left  <= '0;
      ahb_req     <= 1'b0;
      load_enable <= 1'b0;
      byte_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      status      <= ST_IDLE;
    end else begin
      state       <= state_nx;
      byte_cnt    <= byte_cnt_nx;
      words_left  <= words_left_nx;
      ahb_req     <= (state_nx == S_REQ);
      load_enable <= (state_nx == S_LOAD);
      byte_valid  <= (state_nx == S_SHIFT);
      busy        <= (state_nx != S_IDLE);
      frame_done  <= (state_nx == S_DONE);
      status      <= status_of(state_nx);
    end
  end

  assign shift_enable = (state == S_SHIFT) && byte_ready;

endmodule
`default_nettype wire

// File: tb/tb_fifo_r_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_r_ctrl
//  Description : Directed self-checking bench for fifo_r_ctrl. Inputs change
//                1 time unit after the rising edge, and outputs are checked
//                at least 1 unit later in the same cycle.
//  Build macro : FIFO_R_CTRL_TIMEOUT_EN selects the watchdog expectations
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_r_ctrl;

  localparam int CNT_W = 16;

  logic             HCLK       = 1'b0;
  logic             HRESETn    = 1'b0;
  logic             start      = 1'b0;
  logic [CNT_W-1:0] num_words  = '0;
  logic             ahb_done   = 1'b0;
  logic             byte_ready = 1'b0;
  logic             ahb_req;
  logic             load_enable;
  logic             shift_enable;
  logic [1:0]       status;
  logic             byte_valid;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] words_left;

  int total  = 0;
  int passed = 0;

  fifo_r_ctrl #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (8)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .start        (start),
    .num_words    (num_words),
    .ahb_req      (ahb_req),
    .ahb_done     (ahb_done),
    .byte_ready   (byte_ready),
    .load_enable  (load_enable),
    .shift_enable (shift_enable),
    .status       (status),
    .byte_valid   (byte_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .words_left   (words_left)
  );

  always #5 HCLK = ~HCLK;

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "bench time limit");
  end

  initial begin
    int          n;
    int          shifts, loads, rises, fourth_c, req2_c, fd_c, fd_n;
    logic        prev_req;
    logic [3:0]  pat;
    logic [CNT_W-1:0] wl_req2;

    // ---------------- reset sequence ----------------
    cyc(); cyc(); cyc();
    HRESETn = 1'b1;
    cyc(); #1;
    check("rst_ahb_req", ahb_req, 0);
    check("rst_load", load_enable, 0);
    check("rst_shift", shift_enable, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_status", status, 0);
    check("rst_words_left", words_left, 0);

    // ---------------- single word ----------------
    start = 1'b1; num_words = 16'd1;
    cyc();                                    // REQ cycle 1
    start = 1'b0; num_words = '0; #1;
    check("t1_req", ahb_req, 1);
    check("t1_status_fetch", status, 1);
    check("t1_words_left", words_left, 1);
    check("t1_busy", busy, 1);
    cyc();                                    // REQ cycle 2
    cyc();                                    // REQ cycle 3: ahb_done
    ahb_done = 1'b1; #1;
    check("t1_req_held", ahb_req, 1);
    cyc();                                    // LOAD
    ahb_done = 1'b0; byte_ready = 1'b1; #1;
    check("t1_load", load_enable, 1);
    check("t1_req_drop", ahb_req, 0);
    check("t1_no_shift_in_load", shift_enable, 0);
    cyc();                                    // first SHIFT cycle
    #1;
    check("t1_load_one_cycle", load_enable, 0);
    check("t1_byte_valid", byte_valid, 1);
    check("t1_status_stream", status, 2);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (shift_enable) n++;
      cyc();
    end
    // DONE: the 7th cycle counting the ahb_done cycle as the first
    byte_ready = 1'b0; #1;
    check("t1_shift_count", n, 4);
    check("t1_frame_done", frame_done, 1);
    check("t1_words_left_end", words_left, 0);
    check("t1_byte_valid_end", byte_valid, 0);
    cyc(); #1;
    check("t1_frame_done_pulse", frame_done, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_status", status, 0);

    // ---------------- backpressure, two words ----------------
    // byte_ready follows 1,0,0,1 from the start cycle; ahb_done answers each
    // request in its first cycle.
    // Hand trace: c1 REQ, c2 LOAD, shifts at c3,c4,c7,c8, c9 REQ, c10 LOAD,
    // shifts at c11,c12,c15,c16, c17 DONE.
    pat = 4'b1001;
    shifts = 0; loads = 0; rises = 0; fourth_c = -1; req2_c = -1;
    fd_c = -1; fd_n = 0; prev_req = 1'b0; wl_req2 = '0;
    for (int c = 0; c < 22; c++) begin
      start      = (c == 0);
      num_words  = 16'd2;
      byte_ready = pat[c % 4];
      ahb_done   = ahb_req;
      #1;
      if (shift_enable) begin
        shifts++;
        if (shifts == 4) fourth_c = c;
      end
      if (load_enable) loads++;
      if (ahb_req && !prev_req) begin
        rises++;
        if (rises == 2) begin
          req2_c  = c;
          wl_req2 = words_left;
        end
      end
      prev_req = ahb_req;
      if (frame_done) begin
        fd_n++;
        fd_c = c;
      end
      cyc();
    end
    start = 1'b0; byte_ready = 1'b0; ahb_done = 1'b0; num_words = '0; #1;
    check("bp_shifts", shifts, 8);
    check("bp_loads", loads, 2);
    check("bp_req_rises", rises, 2);
    check("bp_fourth_shift_cyc", fourth_c, 8);
    check("bp_second_req_cyc", req2_c, 9);
    check("bp_words_left_word2", wl_req2, 1);
    check("bp_frame_done_count", fd_n, 1);
    check("bp_frame_done_cyc", fd_c, 17);
    check("bp_idle", busy, 0);

    // ---------------- inputs ignored while idle ----------------
    ahb_done = 1'b1; byte_ready = 1'b1;
    cyc(); #1;
    check("idle_ign_busy", busy, 0);
    check("idle_ign_load", load_enable, 0);
    check("idle_ign_shift", shift_enable, 0);
    ahb_done = 1'b0; byte_ready = 1'b0;

    // ---------------- zero-word start ----------------
    start = 1'b1; num_words = '0;
    cyc();
    start = 1'b0; #1;
    check("zero_frame_done", frame_done, 1);
    check("zero_no_req", ahb_req, 0);
    check("zero_busy", busy, 1);
    cyc(); #1;
    check("zero_frame_done_pulse", frame_done, 0);
    check("zero_idle", busy, 0);
    check("zero_no_req_after", ahb_req, 0);

    // ---------------- ignored start, then reset mid-frame ----------------
    start = 1'b1; num_words = 16'd3;
    cyc();                                    // REQ
    start = 1'b0; ahb_done = 1'b1;
    cyc();                                    // LOAD
    ahb_done = 1'b0; byte_ready = 1'b1;
    cyc();                                    // SHIFT, byte 0 accepted
    cyc();                                    // SHIFT, byte 1 accepted
    start = 1'b1; num_words = 16'd7; #1;
    check("mid_shift_accept", shift_enable, 1);
    cyc();                                    // SHIFT, byte count now 2
    start = 1'b0; byte_ready = 1'b0; #1;
    check("mid_words_left_kept", words_left, 3);
    check("mid_status_stream", status, 2);
    check("mid_byte_valid", byte_valid, 1);
    check("mid_backpressure", shift_enable, 0);
    HRESETn = 1'b0;
    cyc(); #1;
    check("mrst_byte_valid", byte_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_status", status, 0);
    check("mrst_frame_done", frame_done, 0);
    check("mrst_words_left", words_left, 0);
    HRESETn = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      if (frame_done || busy) n++;
    end
    check("mrst_stays_idle", n, 0);

    // ---------------- REQ without ahb_done ----------------
    start = 1'b1; num_words = 16'd1;
    cyc();                                    // REQ cycle 1
    start = 1'b0; num_words = '0;
    repeat (7) cyc();                         // REQ cycle 8
    #1;
    check("to_req_cyc8", ahb_req, 1);
    check("to_status_cyc8", status, 1);
    cyc(); #1;
`ifdef FIFO_R_CTRL_TIMEOUT_EN
    check("to_status_err", status, 3);
    check("to_req_drop", ahb_req, 0);
    check("to_busy_err", busy, 1);
    start = 1'b1;
    cyc();
    start = 1'b0; #1;
    check("to_exit_status", status, 0);
    check("to_exit_busy", busy, 0);
    check("to_exit_no_req", ahb_req, 0);
`else
    check("wait_status_cyc9", status, 1);
    check("wait_req_cyc9", ahb_req, 1);
    repeat (20) cyc();
    #1;
    check("wait_status_long", status, 1);
    check("wait_req_long", ahb_req, 1);
    ahb_done = 1'b1;
    cyc();
    ahb_done = 1'b0; #1;
    check("wait_load_after_done", load_enable, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
